// File: rtl/gan_batch_scheduler.sv
// Sequences a batch of GAN core runs: one sample handshake, one core_start, one result per sample.
// Optional score accumulator is compiled in with `define GAN_SCORE_ACCUM_EN.
module gan_batch_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 5,
  parameter int TMO_CYC    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   cfg_mode,
  input  logic [LEN_W-1:0]             cfg_batch_len,
  input  logic                         batch_start,
  input  logic                         batch_abort,
  output logic                         batch_busy,
  output logic                         batch_done,
  output logic                         err,
  input  logic                         smp_valid,
  output logic                         smp_ready,
  output logic [1:0]                   core_mode,
  output logic                         core_start,
  input  logic                         core_busy,
  input  logic                         core_done,
  input  logic signed [DATA_WIDTH-1:0] core_score,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [DATA_WIDTH-1:0] res_score,
  output logic [LEN_W-2:0]             res_idx,
  output logic signed [DATA_WIDTH+7:0] score_sum
);

  localparam int                TMO_W    = $clog2(TMO_CYC + 1);
  // RUN is entered one cycle after core_start, so the timeout fires two counts early
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 2);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(2 ** (LEN_W - 1));

  typedef enum logic [2:0] {IDLE, WAIT_SMP, ISSUE, RUN, RESULT, FIN} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-2:0]  cnt;
  logic [TMO_W-1:0]  tmo;
  logic              cfg_bad;
  logic              last_smp;
  logic              abort_now;

  assign cfg_bad    = (cfg_batch_len == '0) || (cfg_batch_len > LEN_MAX) || (cfg_mode == 2'b11);
  assign last_smp   = ({1'b0, cnt} == (len_q - LEN_W'(1)));
  assign abort_now  = batch_abort && (state != IDLE);
  assign batch_busy = (state != IDLE);
  assign smp_ready  = (state == WAIT_SMP) && !core_busy;
  assign res_idx    = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      core_mode  <= 2'b00;
      core_start <= 1'b0;
      res_valid  <= 1'b0;
      res_score  <= '0;
      len_q      <= '0;
      cnt        <= '0;
      tmo        <= '0;
      batch_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      batch_done <= 1'b0;
      err        <= 1'b0;
      if (abort_now) begin
        state     <= IDLE;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (batch_start) begin
              if (cfg_bad) begin
                err <= 1'b1;
              end else begin
                core_mode <= cfg_mode;
                len_q     <= cfg_batch_len;
                cnt       <= '0;
                state     <= WAIT_SMP;
              end
            end
          end
          WAIT_SMP: begin
            if (smp_valid && !core_busy) begin
              core_start <= 1'b1;
              state      <= ISSUE;
            end
          end
          ISSUE: begin
            tmo   <= '0;
            state <= RUN;
          end
          RUN: begin
            if (core_done) begin
              res_score <= (core_mode == 2'b00) ? '0 : core_score;
              res_valid <= 1'b1;
              state     <= RESULT;
            end else if (tmo == TMO_LAST) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              tmo <= tmo + TMO_W'(1);
            end
          end
          RESULT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (last_smp) begin
                batch_done <= 1'b1;
                state      <= FIN;
              end else begin
                cnt   <= cnt + 1'b1;
                state <= WAIT_SMP;
              end
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef GAN_SCORE_ACCUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_sum <= '0;
    end else if (!abort_now) begin
      if (state == IDLE && batch_start && !cfg_bad)
        score_sum <= '0;
      else if (state == RESULT && res_ready)
        score_sum <= score_sum + {{8{res_score[DATA_WIDTH-1]}}, res_score};
    end
  end
`else
  assign score_sum = '0;
`endif

endmodule

// File: tb/tb_gan_batch_scheduler.sv
// Directed bench for gan_batch_scheduler; sum checks follow GAN_SCORE_ACCUM_EN.
module tb_gan_batch_scheduler;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         cfg_mode = 2'b00;
  logic [4:0]         cfg_batch_len = 5'd0;
  logic               batch_start = 1'b0;
  logic               batch_abort = 1'b0;
  logic               batch_busy, batch_done, err;
  logic               smp_valid = 1'b0;
  logic               smp_ready;
  logic [1:0]         core_mode;
  logic               core_start;
  logic               core_busy = 1'b0;
  logic               core_done = 1'b0;
  logic signed [15:0] core_score = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic signed [15:0] res_score;
  logic [3:0]         res_idx;
  logic signed [23:0] score_sum;

  int n_chk = 0;
  int n_pass = 0;
  int cs_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  gan_batch_scheduler #(.DATA_WIDTH(16), .LEN_W(5), .TMO_CYC(255)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_batch_len(cfg_batch_len),
    .batch_start(batch_start), .batch_abort(batch_abort), .batch_busy(batch_busy),
    .batch_done(batch_done), .err(err), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .core_mode(core_mode), .core_start(core_start), .core_busy(core_busy),
    .core_done(core_done), .core_score(core_score), .res_valid(res_valid),
    .res_ready(res_ready), .res_score(res_score), .res_idx(res_idx), .score_sum(score_sum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_start) cs_cnt++;
    if (batch_done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [1:0] mode, input logic [4:0] len);
    cfg_mode = mode;
    cfg_batch_len = len;
    batch_start = 1'b1;
    tick();
    batch_start = 1'b0;
    check("accept_busy", {31'b0, batch_busy}, 1);
    check("accept_err", {31'b0, err}, 0);
  endtask

  // Entered in WAIT_SMP; core_done arrives 5 cycles after core_start.
  task automatic do_sample(input logic [15:0] score, input logic [15:0] exp_score,
                           input logic [3:0] exp_idx, input logic [1:0] exp_mode, input int hold);
    logic [15:0] s_score;
    logic [3:0]  s_idx;
    core_busy = 1'b1;
    #1 check("smp_rdy_core_busy", {31'b0, smp_ready}, 0);
    core_busy = 1'b0;
    smp_valid = 1'b1;
    #1 check("smp_rdy", {31'b0, smp_ready}, 1);
    check("res_vld_in_wait", {31'b0, res_valid}, 0);
    tick();
    smp_valid = 1'b0;
    check("core_start", {31'b0, core_start}, 1);
    check("core_mode", {30'b0, core_mode}, {30'b0, exp_mode});
    check("smp_rdy_in_issue", {31'b0, smp_ready}, 0);
    tick();
    check("core_start_pulse", {31'b0, core_start}, 0);
    repeat (4) tick();
    core_done = 1'b1;
    core_score = score;
    check("res_vld_before_done", {31'b0, res_valid}, 0);
    tick();
    core_done = 1'b0;
    core_score = '0;
    check("res_vld", {31'b0, res_valid}, 1);
    check("res_score", {16'b0, res_score}, {16'b0, exp_score});
    check("res_idx", {28'b0, res_idx}, {28'b0, exp_idx});
    s_score = res_score;
    s_idx = res_idx;
    for (int i = 0; i < hold; i++) begin
      smp_valid = 1'b1;
      tick();
      check("hold_vld", {31'b0, res_valid}, 1);
      check("hold_score", {16'b0, res_score}, {16'b0, s_score});
      check("hold_idx", {28'b0, res_idx}, {28'b0, s_idx});
      check("hold_smp_rdy", {31'b0, smp_ready}, 0);
    end
    smp_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_vld_after_hs", {31'b0, res_valid}, 0);
  endtask

  task automatic check_fin(input logic [23:0] exp_sum);
    check("batch_done", {31'b0, batch_done}, 1);
`ifdef GAN_SCORE_ACCUM_EN
    check("score_sum", {8'b0, score_sum}, {8'b0, exp_sum});
`else
    check("score_sum_zero", {8'b0, score_sum}, {8'b0, 24'h0 & exp_sum});
`endif
    tick();
    check("batch_done_pulse", {31'b0, batch_done}, 0);
    check("idle_busy", {31'b0, batch_busy}, 0);
  endtask

  task automatic bad_start(input string tag, input logic [1:0] mode, input logic [4:0] len);
    cfg_mode = mode;
    cfg_batch_len = len;
    batch_start = 1'b1;
    tick();
    batch_start = 1'b0;
    check({tag, "_err"}, {31'b0, err}, 1);
    check({tag, "_busy"}, {31'b0, batch_busy}, 0);
    tick();
    check({tag, "_err_pulse"}, {31'b0, err}, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, batch_busy}, 0);
    check("rst_core_start", {31'b0, core_start}, 0);
    check("rst_core_mode", {30'b0, core_mode}, 0);
    check("rst_smp_rdy", {31'b0, smp_ready}, 0);
    check("rst_res_vld", {31'b0, res_valid}, 0);
    check("rst_res_score", {16'b0, res_score}, 0);
    check("rst_res_idx", {28'b0, res_idx}, 0);
    check("rst_sum", {8'b0, score_sum}, 0);
    check("rst_done_err", {30'b0, batch_done, err}, 0);
    rst = 1'b0;
    tick();

    // Full mode, three samples with a negative middle score.
    start_batch(2'b10, 5'd3);
    do_sample(16'h0100, 16'h0100, 4'd0, 2'b10, 0);
    do_sample(16'hFF00, 16'hFF00, 4'd1, 2'b10, 0);
    do_sample(16'h0080, 16'h0080, 4'd2, 2'b10, 0);
    check_fin(24'h000080);

    // Generator mode forces a zero score.
    start_batch(2'b00, 5'd1);
    do_sample(16'h1234, 16'h0000, 4'd0, 2'b00, 0);
    check_fin(24'h000000);
    check("done_count_gen", done_cnt, 2);

    bad_start("len0", 2'b10, 5'd0);
    bad_start("mode11", 2'b11, 5'd3);
    bad_start("len17", 2'b01, 5'd17);
    check("cs_count_bad", cs_cnt, 4);
    check("err_count_bad", err_cnt, 3);

    // Largest length is accepted; abort from WAIT_SMP returns to idle.
    start_batch(2'b01, 5'd16);
    batch_start = 1'b1;
    cfg_batch_len = 5'd0;
    tick();
    batch_start = 1'b0;
    check("start_while_busy_err", {31'b0, err}, 0);
    batch_abort = 1'b1;
    tick();
    batch_abort = 1'b0;
    check("abort_wait_busy", {31'b0, batch_busy}, 0);

    // Core never answers.
    start_batch(2'b01, 5'd2);
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
    check("tmo_core_start", {31'b0, core_start}, 1);
    k = 0;
    while (k < 300 && !err) begin
      tick();
      k++;
    end
    check("tmo_cycles", k, 255);
    check("tmo_busy", {31'b0, batch_busy}, 0);
    check("tmo_res_vld", {31'b0, res_valid}, 0);
    tick();
    check("tmo_err_pulse", {31'b0, err}, 0);
    check("tmo_no_done", done_cnt, 2);

    // Stalled consumer, then a sum crossing the 16-bit range.
    start_batch(2'b01, 5'd2);
    do_sample(16'h7F00, 16'h7F00, 4'd0, 2'b01, 10);
    do_sample(16'h0200, 16'h0200, 4'd1, 2'b01, 0);
    check_fin(24'h008100);

    // Abort coinciding with core_done.
    start_batch(2'b10, 5'd2);
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
    repeat (5) tick();
    core_done = 1'b1;
    core_score = 16'h0400;
    batch_abort = 1'b1;
    tick();
    core_done = 1'b0;
    batch_abort = 1'b0;
    check("abort_res_vld", {31'b0, res_valid}, 0);
    check("abort_busy", {31'b0, batch_busy}, 0);
    repeat (3) tick();
    check("abort_no_result", {31'b0, res_valid}, 0);

    // Reset in the middle of RUN.
    start_batch(2'b10, 5'd2);
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_run_busy", {31'b0, batch_busy}, 0);
    check("rst_run_res_vld", {31'b0, res_valid}, 0);
    check("rst_run_sum", {8'b0, score_sum}, 0);
    tick();
    rst = 1'b0;
    core_done = 1'b1;
    core_score = 16'h0300;
    tick();
    core_done = 1'b0;
    check("rst_run_no_result", {31'b0, res_valid}, 0);
    repeat (3) tick();
    check("final_done_count", done_cnt, 3);
    check("final_cs_count", cs_cnt, 9);
    check("final_err_count", err_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
